// File: rtl/serial_frame_rx_fifo_if.sv
// Purpose: bundles the serial line, the FIFO read side and the status flags of
//          serial_frame_rx_fifo into one port.
// Ports:   master = line driver / message consumer, slave = the receiver itself.
//          serial, msg_rd, err_clr flow master->slave; msg, msg_valid, noti,
//          level, par_err, frm_err, ovf flow slave->master.
interface serial_frame_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              serial;
  logic              msg_rd;
  logic              err_clr;
  logic [DATA_W-1:0] msg;
  logic              msg_valid;
  logic              noti;
  logic [LVL_W-1:0]  level;
  logic              par_err;
  logic              frm_err;
  logic              ovf;

  modport master (
    output serial, msg_rd, err_clr,
    input  msg, msg_valid, noti, level, par_err, frm_err, ovf
  );

  modport slave (
    input  serial, msg_rd, err_clr,
    output msg, msg_valid, noti, level, par_err, frm_err, ovf
  );
endinterface

// File: rtl/serial_frame_rx_fifo.sv
// Purpose: oversampled async serial receiver (start, DATA_W bits LSB first,
//          optional parity, STOP_BITS stops) feeding a DEPTH-entry show-ahead FIFO.
// Latency: byte visible on msg/msg_valid one clk after the commit cycle, which
//          itself follows the last stop-bit sample; noti pulses in the commit cycle.
// Backpressure: none on the line; a good frame arriving at a full FIFO with no
//          pop in its commit cycle is dropped and flagged in the sticky ovf.
// Ports:   clk (OVERSAMPLE x baud), rst_n (async, active low), bus (slave modport):
//          serial in, msg_rd/err_clr in, msg/msg_valid/level/noti/status flags out.
module serial_frame_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int OVERSAMPLE  = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int DEPTH       = 4,
  parameter int TERM_CHAR   = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  serial_frame_rx_fifo_if.slave bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int CW    = $clog2(OVERSAMPLE);
  localparam int BW    = 4;

  // Tick counter reload values: half a bit to reach the middle of the start
  // bit, a whole bit thereafter so every sample stays mid-bit.
  localparam logic [CW-1:0]     HALF_LD   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0]     FULL_LD   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]     LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0]     LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [DATA_W-1:0] TERM      = DATA_W'(TERM_CHAR);
  localparam logic              ODD_PAR   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchroniser and falling-edge detector. All three flops reset to 1
  // (idle line) so a line held low out of reset is not taken as a start bit.
  // ---------------------------------------------------------------------------
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic rx;
  logic fall;

  always_comb begin
    sync1_d = bus.serial;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign rx = sync2_q;
  // prev_q tracks the line in every state, so after a low stop bit the line
  // must return high before another edge can be seen.
  assign fall = prev_q & ~rx;

  // ---------------------------------------------------------------------------
  // Frame FSM. commit_q is a registered one-cycle strobe raised by the last
  // stop sample; frm_bad_q/par_bad_q and shift_q hold the verdict and the
  // byte through that commit cycle.
  // ---------------------------------------------------------------------------
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_bad_q;
  logic              frm_bad_q;
  logic              commit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      frm_bad_q <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fall) begin
            cnt_q   <= HALF_LD;
            state_q <= S_START;
          end
        end

        S_START: begin
          if (cnt_q == '0) begin
            if (!rx) begin
              cnt_q     <= FULL_LD;
              bit_q     <= '0;
              par_bad_q <= 1'b0;
              frm_bad_q <= 1'b0;
              state_q   <= S_DATA;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rx, shift_q[DATA_W-1:1]};
            cnt_q   <= FULL_LD;
            if (bit_q == LAST_DATA) begin
              bit_q   <= '0;
              state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_PARITY: begin
          if (cnt_q == '0) begin
            // Even parity expects XOR of the data; odd expects its inverse.
            par_bad_q <= rx ^ ((^shift_q) ^ ODD_PAR);
            cnt_q     <= FULL_LD;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_STOP: begin
          if (cnt_q == '0) begin
            if (!rx) begin
              frm_bad_q <= 1'b1;
            end
            if (bit_q == LAST_STOP) begin
              // Return to IDLE mid stop bit so a start bit that follows
              // immediately is still caught by the edge detector.
              commit_q <= 1'b1;
              state_q  <= S_IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
              cnt_q <= FULL_LD;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Commit decision. Error priority: framing, then parity, then overflow.
  // A pop in the commit cycle frees a slot, so a full FIFO still accepts.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q,  count_d;
  logic              par_err_q, par_err_d;
  logic              frm_err_q, frm_err_d;
  logic              ovf_q,     ovf_d;

  logic frame_ok;
  logic fifo_full;
  logic pop;
  logic wr;
  logic frm_set;
  logic par_set;
  logic ovf_set;

  assign fifo_full = (count_q == FULL_LVL);
  assign pop       = bus.msg_rd & (count_q != '0);
  assign frame_ok  = commit_q & ~frm_bad_q & ~par_bad_q;
  assign frm_set   = commit_q & frm_bad_q;
  assign par_set   = commit_q & ~frm_bad_q & par_bad_q;
  assign ovf_set   = frame_ok & fifo_full & ~pop;
  assign wr        = frame_ok & (~fifo_full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Sticky flags: a new error in the same cycle as err_clr wins.
    par_err_d = (par_err_q & ~bus.err_clr) | par_set;
    frm_err_d = (frm_err_q & ~bus.err_clr) | frm_set;
    ovf_d     = (ovf_q     & ~bus.err_clr) | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      par_err_q <= par_err_d;
      frm_err_q <= frm_err_d;
      ovf_q     <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. msg is the head entry (show-ahead); memory resets to zero so msg
  // reads 0 out of reset.
  // ---------------------------------------------------------------------------
  assign bus.msg       = mem_q[rd_ptr_q];
  assign bus.msg_valid = (count_q != '0);
  assign bus.level     = count_q;
  assign bus.noti      = wr & (shift_q == TERM);
  assign bus.par_err   = par_err_q;
  assign bus.frm_err   = frm_err_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_frame_rx_fifo.sv
module tb_serial_frame_rx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   noti_cnt = 0;

  always #5 clk = ~clk;

  serial_frame_rx_fifo_if #(.DATA_W(8), .DEPTH(4)) bus ();

  serial_frame_rx_fifo #(
    .DATA_W      (8),
    .OVERSAMPLE  (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .DEPTH       (4),
    .TERM_CHAR   (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always @(negedge clk) begin
    if (bus.noti === 1'b1) noti_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1+even-parity frame, 8 clocks per bit, starting on a negedge.
  // pop_commit raises msg_rd during the receiver's commit cycle, which falls
  // 87 clocks after the start-bit edge (2 sync + 1 detect + 4 half-bit + 80).
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop, input bit pop_commit);
    logic [10:0] bits;
    bits = {~bad_stop, (^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      bus.serial = bits[i];
      for (int c = 0; c < 8; c++) begin
        if (pop_commit && i == 10 && c == 7) bus.msg_rd = 1'b1;
        @(negedge clk);
      end
    end
    bus.msg_rd = 1'b0;
    bus.serial = 1'b1;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk(tag, bus.msg, exp);
    bus.msg_rd = 1'b1;
    @(negedge clk);
    bus.msg_rd = 1'b0;
  endtask

  task automatic clr_err();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.serial  = 1'b1;
    bus.msg_rd  = 1'b0;
    bus.err_clr = 1'b0;
    idle(3);

    chk("rst_msg",       bus.msg,       0);
    chk("rst_msg_valid", bus.msg_valid, 0);
    chk("rst_noti",      bus.noti,      0);
    chk("rst_level",     bus.level,     0);
    chk("rst_flags",     {bus.par_err, bus.frm_err, bus.ovf}, 0);

    rst_n = 1'b1;
    idle(4);
    chk("idle_level", bus.level, 0);

    // Back-to-back frames, terminator last.
    send_frame(8'h31, 0, 0, 0);
    chk("noti_after_31", noti_cnt, 0);
    send_frame(8'h32, 0, 0, 0);
    chk("noti_after_32", noti_cnt, 0);
    send_frame(8'h00, 0, 0, 0);
    chk("noti_after_00", noti_cnt, 1);
    idle(4);
    chk("three_level", bus.level, 3);
    chk("three_head",  bus.msg,   8'h31);
    chk("three_valid", bus.msg_valid, 1);
    chk("three_flags", {bus.par_err, bus.frm_err, bus.ovf}, 0);

    // Parity error drops the byte.
    send_frame(8'h35, 1, 0, 0);
    idle(4);
    chk("par_err_set",   bus.par_err, 1);
    chk("par_level",     bus.level,   3);
    clr_err();
    chk("par_err_clear", bus.par_err, 0);

    // err_clr held across a parity-error commit: the new error wins.
    bus.err_clr = 1'b1;
    send_frame(8'h35, 1, 0, 0);
    bus.err_clr = 1'b0;
    idle(2);
    chk("par_set_wins", bus.par_err, 1);
    clr_err();
    chk("par_clr_again", bus.par_err, 0);

    // Framing error, then a good frame after the line recovers.
    send_frame(8'h40, 0, 1, 0);
    idle(4);
    chk("frm_err_set", bus.frm_err, 1);
    chk("frm_level",   bus.level,   3);
    send_frame(8'h41, 0, 0, 0);
    idle(4);
    chk("after_frm_level", bus.level,   4);
    chk("frm_sticky",      bus.frm_err, 1);
    chk("after_frm_par",   bus.par_err, 0);
    pop_chk("pop0", 8'h31);
    pop_chk("pop1", 8'h32);
    pop_chk("pop2", 8'h00);
    pop_chk("pop3", 8'h41);
    chk("drained_level", bus.level, 0);
    clr_err();
    chk("frm_err_clear", bus.frm_err, 0);

    // Pop on an empty FIFO is ignored.
    bus.msg_rd = 1'b1;
    idle(1);
    bus.msg_rd = 1'b0;
    chk("empty_pop_level", bus.level, 0);

    // Two-clock low glitch on the idle line.
    bus.serial = 1'b0;
    idle(2);
    bus.serial = 1'b1;
    idle(20);
    chk("glitch_flags", {bus.par_err, bus.frm_err, bus.ovf}, 0);
    chk("glitch_level", bus.level, 0);

    // Overflow: five frames into four entries.
    for (int k = 0; k < 5; k++) begin
      send_frame(8'h30 + 8'(k), 0, 0, 0);
    end
    idle(4);
    chk("ovf_level", bus.level, 4);
    chk("ovf_set",   bus.ovf,   1);
    chk("ovf_head",  bus.msg,   8'h30);

    // Sixth frame commits while the head is popped: accepted, level stays full.
    send_frame(8'h35, 0, 0, 1);
    idle(4);
    chk("full_pop_level", bus.level, 4);
    chk("full_pop_ovf",   bus.ovf,   1);
    pop_chk("ovf_pop0", 8'h31);
    pop_chk("ovf_pop1", 8'h32);
    pop_chk("ovf_pop2", 8'h33);
    pop_chk("ovf_pop3", 8'h35);
    chk("ovf_drained", bus.level, 0);
    clr_err();
    chk("ovf_clear", bus.ovf, 0);

    // Reset in the middle of a frame empties the FIFO and aborts the frame.
    send_frame(8'h12, 0, 0, 0);
    idle(4);
    chk("pre_rst_level", bus.level, 1);
    bus.serial = 1'b0;
    idle(8);
    bus.serial = 1'b1;
    idle(8);
    bus.serial = 1'b0;
    idle(4);
    rst_n = 1'b0;
    idle(2);
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_valid", bus.msg_valid, 0);
    bus.serial = 1'b1;
    idle(1);
    rst_n = 1'b1;
    idle(4);
    send_frame(8'h39, 0, 0, 0);
    idle(4);
    chk("post_rst_level", bus.level, 1);
    chk("post_rst_flags", {bus.par_err, bus.frm_err, bus.ovf}, 0);
    pop_chk("post_rst_msg", 8'h39);
    chk("post_rst_empty", bus.msg_valid, 0);
    chk("noti_total", noti_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
